// File: rtl/chirp_sweep_ctrl.sv
// Stepped linear-chirp sequencer: drives the phase-increment words of NUM_CH NCOs.
// Channel k follows base + k*ch_offset. Base steps from start_inc toward stop_inc.
module chirp_sweep_ctrl #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned DEF_START  = 42950,
  parameter int unsigned DEF_STEP   = 439883,
  parameter int unsigned DEF_STOP   = 429926226,
  parameter int unsigned DEF_OFFSET = 1000,
  parameter int unsigned DEF_DWELL  = 50000,
  parameter int unsigned DEF_GAP    = 1000
) (
  input  logic                   sys_clk,
  input  logic                   reset_n,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   continuous_i,
  input  logic                   cfg_we_i,
  input  logic [2:0]             cfg_addr_i,
  input  logic [31:0]            cfg_wdata_i,
  output logic                   cfg_err_o,
  output logic [NUM_CH*32-1:0]   phi_inc_o,
  output logic                   nco_sync_n_o,
  output logic                   sweep_active_o,
  output logic                   sweep_done_o,
  output logic [15:0]            step_idx_o
);

  localparam int unsigned W    = 32;
  localparam int unsigned IW   = 16;
  localparam int unsigned PHIW = NUM_CH * W;

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_SWEEP, S_GAP} state_e;

  state_e          state_q;
  logic [W-1:0]    start_inc_q, step_inc_q, stop_inc_q, offset_q, dwell_q, gap_q;
  logic [W-1:0]    base_q, cnt_q;
  logic [PHIW-1:0] phi_q;
  logic            nco_sync_n_q, active_q, done_q, err_q;
  logic [IW-1:0]   step_idx_q;

  logic [W:0]      base_d;
  logic [W-1:0]    dwell_last, phi_src, phi_acc;
  logic [PHIW-1:0] phi_d;
  logic            dwell_end, gap_end, step_ok, cfg_ok;

  // Step arithmetic: 33-bit sum so a wrapped base can never pass the stop check.
  always_comb begin
    base_d     = {1'b0, base_q} + {1'b0, step_inc_q};
    step_ok    = (base_d <= {1'b0, stop_inc_q});
    dwell_last = (dwell_q == '0) ? '0 : dwell_q - W'(1);
    dwell_end  = (cnt_q == dwell_last);
    gap_end    = (cnt_q == gap_q - W'(1));
    cfg_ok     = (state_q == S_IDLE) && (cfg_addr_i <= 3'd5);
    phi_src    = (state_q == S_PRIME) ? base_q : base_d[W-1:0];
  end

  // Per-channel increments, each channel one ch_offset above the previous (mod 2^32).
  always_comb begin
    phi_acc = phi_src;
    phi_d   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      phi_d[k*W +: W] = phi_acc;
      phi_acc         = phi_acc + offset_q;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      start_inc_q  <= W'(DEF_START);
      step_inc_q   <= W'(DEF_STEP);
      stop_inc_q   <= W'(DEF_STOP);
      offset_q     <= W'(DEF_OFFSET);
      dwell_q      <= W'(DEF_DWELL);
      gap_q        <= W'(DEF_GAP);
      base_q       <= '0;
      cnt_q        <= '0;
      phi_q        <= '0;
      nco_sync_n_q <= 1'b1;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      step_idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= cfg_we_i && !cfg_ok;
      if (cfg_we_i && cfg_ok) begin
        case (cfg_addr_i)
          3'd0:    start_inc_q <= cfg_wdata_i;
          3'd1:    step_inc_q  <= cfg_wdata_i;
          3'd2:    stop_inc_q  <= cfg_wdata_i;
          3'd3:    offset_q    <= cfg_wdata_i;
          3'd4:    dwell_q     <= cfg_wdata_i;
          3'd5:    gap_q       <= cfg_wdata_i;
          default: ;
        endcase
      end

      case (state_q)
        S_IDLE: begin
          if (start_i && !stop_i) begin
            state_q      <= S_PRIME;
            nco_sync_n_q <= 1'b0;
            base_q       <= start_inc_q;
            step_idx_q   <= '0;
            cnt_q        <= '0;
          end
        end
        S_PRIME: begin
          state_q      <= S_SWEEP;
          phi_q        <= phi_d;
          active_q     <= 1'b1;
          nco_sync_n_q <= 1'b1;
        end
        S_SWEEP: begin
          if (!dwell_end) begin
            cnt_q <= cnt_q + W'(1);
          end else if (step_ok) begin
            base_q <= base_d[W-1:0];
            phi_q  <= phi_d;
            cnt_q  <= '0;
            if (step_idx_q != '1) step_idx_q <= step_idx_q + IW'(1);
          end else begin
            done_q   <= 1'b1;
            active_q <= 1'b0;
            phi_q    <= '0;
            cnt_q    <= '0;
            if (!continuous_i) begin
              state_q <= S_IDLE;
            end else if (gap_q != '0) begin
              state_q <= S_GAP;
            end else begin
              state_q      <= S_PRIME;
              nco_sync_n_q <= 1'b0;
              base_q       <= start_inc_q;
              step_idx_q   <= '0;
            end
          end
        end
        S_GAP: begin
          if (gap_end) begin
            state_q      <= S_PRIME;
            nco_sync_n_q <= 1'b0;
            base_q       <= start_inc_q;
            step_idx_q   <= '0;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q + W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Abort outranks everything above; sweep_done is deliberately not raised.
      if (stop_i && state_q != S_IDLE) begin
        state_q      <= S_IDLE;
        phi_q        <= '0;
        nco_sync_n_q <= 1'b1;
        active_q     <= 1'b0;
        done_q       <= 1'b0;
        step_idx_q   <= '0;
        cnt_q        <= '0;
      end
    end
  end

  assign cfg_err_o      = err_q;
  assign phi_inc_o      = phi_q;
  assign nco_sync_n_o   = nco_sync_n_q;
  assign sweep_active_o = active_q;
  assign sweep_done_o   = done_q;
  assign step_idx_o     = step_idx_q;

endmodule
